nco_tone_scheduler: RTL and testbench

//  Symbol-driven frequency sequencer for the modulator NCO (M-FSK / tone hopping).
//  - Buffers incoming symbols in a small FIFO and maps each one through a programmable tone table to a 32-bit phase increment.
//  - Holds each increment on opFrequency for a programmable dwell (samples per symbol), back-to-back with no gaps.
//  - Drives the NCO reset so phase starts at 0 on the first symbol of a burst and stays continuous across symbol changes.

---
 rtl/nco_tone_scheduler_pkg.sv | 11 +
 rtl/nco_tone_scheduler_sym_fifo.sv | 53 +++++
 rtl/nco_tone_scheduler.sv | 120 ++++++++++++
 tb/tb_nco_tone_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_tone_scheduler_pkg.sv
// Shared types for the NCO tone scheduler: sequencer state and phase-increment word.
package nco_tone_scheduler_pkg;

    typedef enum logic [0:0] {
        IDLE,
        DWELL
    } NCO_SCHED_STATE;

    typedef logic [31:0] PHASE_INC;

endpackage

// File: rtl/nco_tone_scheduler_sym_fifo.sv
// Small synchronous symbol FIFO with registered occupancy count (no fall-through).
module nco_tone_scheduler_sym_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             ipClk,
    input  logic             ipReset,
    input  logic             ipPush,
    input  logic [WIDTH-1:0] ipData,
    input  logic             ipPop,
    output logic [WIDTH-1:0] opData,
    output logic             opFull,
    output logic             opEmpty,
    output logic [CntW-1:0]  opCount
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
    logic [CntW-1:0]  countQ;
    logic             doPush, doPop;

    assign opFull  = (countQ == CntW'(DEPTH));
    assign opEmpty = (countQ == '0);
    assign opCount = countQ;
    assign opData  = mem[rdPtrQ];

    assign doPush = ipPush && !opFull;
    assign doPop  = ipPop && !opEmpty;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + PtrW'(1);
            if (doPop) rdPtrQ <= rdPtrQ + PtrW'(1);
            unique case ({doPush, doPop})
                2'b10:   countQ <= countQ + CntW'(1);
                2'b01:   countQ <= countQ - CntW'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge ipClk) begin
        if (doPush) mem[wrPtrQ] <= ipData;
    end

endmodule

// File: rtl/nco_tone_scheduler.sv
// Symbol-driven NCO frequency sequencer: FIFO -> tone table -> dwell-timed phase increment.
module nco_tone_scheduler
    import nco_tone_scheduler_pkg::*;
#(
    parameter int unsigned TONES      = 4,
    parameter int unsigned SYM_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DWELL_W    = 16
) (
    input  logic               ipClk,
    input  logic               ipReset,
    input  logic               ipEnable,
    input  logic               ipCfgWrite,
    input  logic [SYM_W-1:0]   ipCfgAddr,
    input  logic [31:0]        ipCfgData,
    input  logic [DWELL_W-1:0] ipDwell,
    input  logic [SYM_W-1:0]   ipSymbol,
    input  logic               ipSymbolValid,
    output logic               opSymbolReady,
    output logic [31:0]        opFrequency,
    output logic               opNcoReset,
    output logic               opSymbolStrobe,
    output logic               opBusy,
    output logic               opUnderrun
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    NCO_SCHED_STATE     stateQ, stateD;
    PHASE_INC           toneTable [TONES];
    PHASE_INC           freqQ;
    logic [DWELL_W-1:0] cntQ, dwellLoad;
    logic               strobeQ, underrunQ;
    logic               fifoFull, fifoEmpty;
    logic [CntW-1:0]    fifoCount;
    logic [SYM_W-1:0]   fifoData;
    logic               dwellDone, load;

    nco_tone_scheduler_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SYM_W)
    ) uSymFifo (
        .ipClk   (ipClk),
        .ipReset (ipReset),
        .ipPush  (ipSymbolValid),
        .ipData  (ipSymbol),
        .ipPop   (load),
        .opData  (fifoData),
        .opFull  (fifoFull),
        .opEmpty (fifoEmpty),
        .opCount (fifoCount)
    );

    assert property (@(posedge ipClk) disable iff (!ipReset) fifoEmpty == (fifoCount == '0));

    assign opSymbolReady = !fifoFull;
    assign dwellDone     = (stateQ == DWELL) && (cntQ == '0);
    assign load          = ipEnable && !fifoEmpty && ((stateQ == IDLE) || dwellDone);
    assign dwellLoad     = (ipDwell == '0) ? DWELL_W'(1) : ipDwell;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) stateQ <= IDLE;
        else          stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (load) stateD = DWELL;
            DWELL:   if (dwellDone && !load) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        opNcoReset = 1'b1;
        opBusy     = 1'b0;
        unique case (stateQ)
            DWELL: begin
                opNcoReset = 1'b0;
                opBusy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Table read on a load sees the pre-write value when a config write lands on the same edge.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            cntQ      <= '0;
            freqQ     <= '0;
            strobeQ   <= 1'b0;
            underrunQ <= 1'b0;
        end else begin
            strobeQ   <= load;
            underrunQ <= dwellDone && ipEnable && fifoEmpty;
            if (load) begin
                freqQ <= toneTable[fifoData];
                cntQ  <= dwellLoad - DWELL_W'(1);
            end else if (dwellDone) begin
                freqQ <= '0;
            end else if (stateQ == DWELL) begin
                cntQ <= cntQ - DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            for (int unsigned i = 0; i < TONES; i++) toneTable[i] <= '0;
        end else if (ipCfgWrite) begin
            toneTable[ipCfgAddr] <= ipCfgData;
        end
    end

    assign opFrequency    = freqQ;
    assign opSymbolStrobe = strobeQ;
    assign opUnderrun     = underrunQ;

endmodule

// File: tb/tb_nco_tone_scheduler.sv
// Bench for nco_tone_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_nco_tone_scheduler;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b0;
    logic        ipEnable = 1'b0;
    logic        ipCfgWrite = 1'b0;
    logic [1:0]  ipCfgAddr = '0;
    logic [31:0] ipCfgData = '0;
    logic [15:0] ipDwell = '0;
    logic [1:0]  ipSymbol = '0;
    logic        ipSymbolValid = 1'b0;
    logic        opSymbolReady;
    logic [31:0] opFrequency;
    logic        opNcoReset;
    logic        opSymbolStrobe;
    logic        opBusy;
    logic        opUnderrun;

    int checks = 0;
    int errors = 0;

    nco_tone_scheduler #(
        .TONES      (4),
        .SYM_W      (2),
        .FIFO_DEPTH (4),
        .DWELL_W    (16)
    ) dut (
        .ipClk          (ipClk),
        .ipReset        (ipReset),
        .ipEnable       (ipEnable),
        .ipCfgWrite     (ipCfgWrite),
        .ipCfgAddr      (ipCfgAddr),
        .ipCfgData      (ipCfgData),
        .ipDwell        (ipDwell),
        .ipSymbol       (ipSymbol),
        .ipSymbolValid  (ipSymbolValid),
        .opSymbolReady  (opSymbolReady),
        .opFrequency    (opFrequency),
        .opNcoReset     (opNcoReset),
        .opSymbolStrobe (opSymbolStrobe),
        .opBusy         (opBusy),
        .opUnderrun     (opUnderrun)
    );

    always #5 ipClk = ~ipClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a symbol queue, the tone table, and the remaining cycles of the tone on air.
    logic [1:0]  mq[$];
    logic [31:0] mTbl [4];
    bit          mBusy, mStrobe, mUnder;
    int          mRem;
    logic [31:0] mFreq;

    function automatic void mdlReset();
        mq.delete();
        for (int i = 0; i < 4; i++) mTbl[i] = '0;
        mBusy = 0; mStrobe = 0; mUnder = 0; mRem = 0; mFreq = '0;
    endfunction

    initial begin
        mdlReset();
        forever begin
            @(posedge ipClk or negedge ipReset);
            if (!ipReset) begin
                mdlReset();
            end else begin
                automatic int preSize = mq.size();
                automatic bit canStart = ipEnable && (preSize > 0);
                automatic logic [1:0] s;
                mStrobe = 0;
                mUnder  = 0;
                if (mBusy && mRem > 1) begin
                    mRem--;
                end else if (canStart) begin
                    s = mq.pop_front();
                    mFreq = mTbl[s];
                    mRem = (ipDwell == 0) ? 1 : int'(ipDwell);
                    mBusy = 1;
                    mStrobe = 1;
                end else begin
                    if (mBusy && ipEnable) mUnder = 1;
                    mBusy = 0;
                    mFreq = '0;
                end
                if (ipSymbolValid && preSize < 4) mq.push_back(ipSymbol);
                if (ipCfgWrite) mTbl[ipCfgAddr] = ipCfgData;
            end
        end
    end

    initial begin
        forever begin
            @(negedge ipClk);
            check("freq", opFrequency, mFreq);
            check("ncoReset", 32'(opNcoReset), 32'(!mBusy));
            check("busy", 32'(opBusy), 32'(mBusy));
            check("strobe", 32'(opSymbolStrobe), 32'(mStrobe));
            check("underrun", 32'(opUnderrun), 32'(mUnder));
            check("ready", 32'(opSymbolReady), 32'(mq.size() < 4));
        end
    end

    task automatic tick();
        @(posedge ipClk);
        #2;
    endtask

    task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
        ipCfgWrite = 1'b1;
        ipCfgAddr  = a;
        ipCfgData  = d;
        tick();
        ipCfgWrite = 1'b0;
    endtask

    task automatic push(input logic [1:0] s);
        ipSymbolValid = 1'b1;
        ipSymbol      = s;
        tick();
        ipSymbolValid = 1'b0;
    endtask

    task automatic loadTable();
        cfgWrite(2'd0, 32'h0040_0000);
        cfgWrite(2'd1, 32'h0100_0000);
        cfgWrite(2'd2, 32'h0200_0000);
        cfgWrite(2'd3, 32'h0300_0000);
    endtask

    initial begin
        int strobes, lows, busyCycles;
        logic [31:0] expF [3];
        expF[0] = 32'h0040_0000;
        expF[1] = 32'h0100_0000;
        expF[2] = 32'h0200_0000;

        // Power-on reset
        #12;
        check("rst_freq", opFrequency, 32'h0);
        check("rst_ncoReset", 32'(opNcoReset), 32'h1);
        check("rst_ready", 32'(opSymbolReady), 32'h1);
        tick();
        ipReset = 1'b1;
        loadTable();

        // Single symbol
        ipEnable = 1'b1;
        ipDwell  = 16'd8;
        push(2'd2);
        check("single_idleAfterPush", 32'(opNcoReset), 32'h1);
        tick();
        check("single_freq", opFrequency, 32'h0200_0000);
        check("single_strobe", 32'(opSymbolStrobe), 32'h1);
        check("single_ncoLow", 32'(opNcoReset), 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("single_lastFreq", opFrequency, 32'h0200_0000);
        check("single_lastStrobe", 32'(opSymbolStrobe), 32'h0);
        tick();
        check("single_ncoBack", 32'(opNcoReset), 32'h1);
        check("single_underrun", 32'(opUnderrun), 32'h1);
        check("single_freqZero", opFrequency, 32'h0);

        // Back-to-back, with FIFO filled first
        ipEnable = 1'b0;
        ipDwell  = 16'd4;
        push(2'd0); push(2'd1); push(2'd3); push(2'd2);
        check("b2b_fullReady", 32'(opSymbolReady), 32'h0);
        ipEnable = 1'b1;
        strobes = 0; lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            strobes += int'(opSymbolStrobe);
            lows += int'(!opNcoReset);
        end
        check("b2b_strobes", 32'(strobes), 32'd4);
        check("b2b_ncoLowCycles", 32'(lows), 32'd16);

        // Dwell 0 and 1 both last one cycle
        for (int d = 0; d < 2; d++) begin
            ipEnable = 1'b0;
            ipDwell  = 16'(d);
            push(2'd0); push(2'd1); push(2'd2);
            ipEnable = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("dwellEdge_strobe", 32'(opSymbolStrobe), 32'h1);
                check("dwellEdge_freq", opFrequency, expF[i]);
            end
            tick();
            check("dwellEdge_underrun", 32'(opUnderrun), 32'h1);
        end

        // Enable drop mid-symbol
        ipEnable = 1'b0;
        ipDwell  = 16'd8;
        push(2'd1); push(2'd2); push(2'd3);
        ipEnable = 1'b1;
        tick();
        busyCycles = int'(opBusy);
        ipEnable = 1'b0;
        for (int i = 0; i < 20 && opBusy; i++) begin
            tick();
            busyCycles += int'(opBusy);
        end
        check("enDrop_busyCycles", 32'(busyCycles), 32'd8);
        check("enDrop_noUnderrun", 32'(opUnderrun), 32'h0);
        tick(); tick();
        check("enDrop_stillIdle", 32'(opBusy), 32'h0);
        ipEnable = 1'b1;
        tick();
        check("enDrop_restart", 32'(opSymbolStrobe), 32'h1);
        check("enDrop_restartFreq", opFrequency, 32'h0200_0000);
        for (int i = 0; i < 20; i++) tick();

        // Config write racing a load of the same entry
        ipEnable = 1'b0;
        ipDwell  = 16'd2;
        push(2'd1); push(2'd1);
        ipEnable = 1'b1;
        cfgWrite(2'd1, 32'h0300_0000);
        check("race_oldValue", opFrequency, 32'h0100_0000);
        tick(); tick();
        check("race_newValue", opFrequency, 32'h0300_0000);
        for (int i = 0; i < 4; i++) tick();

        // Reset mid-burst discards the queue
        ipEnable = 1'b0;
        ipDwell  = 16'd8;
        push(2'd2); push(2'd3); push(2'd0);
        ipEnable = 1'b1;
        tick(); tick();
        ipReset = 1'b0;
        #1;
        check("midRst_freq", opFrequency, 32'h0);
        check("midRst_ncoReset", 32'(opNcoReset), 32'h1);
        check("midRst_busy", 32'(opBusy), 32'h0);
        check("midRst_strobe", 32'(opSymbolStrobe), 32'h0);
        tick();
        ipReset = 1'b1;
        #1;
        check("midRst_ready", 32'(opSymbolReady), 32'h1);
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            strobes += int'(opSymbolStrobe);
        end
        check("midRst_fifoEmpty", 32'(strobes), 32'd0);
        loadTable();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            ipSymbolValid = 1'($urandom_range(0, 1));
            ipSymbol      = 2'($urandom_range(0, 3));
            ipEnable      = ($urandom_range(0, 7) != 0);
            ipDwell       = 16'($urandom_range(0, 5));
            ipCfgWrite    = ($urandom_range(0, 9) == 0);
            ipCfgAddr     = 2'($urandom_range(0, 3));
            ipCfgData     = $urandom;
            if ($urandom_range(0, 499) == 0) ipReset = 1'b0;
            tick();
            ipReset = 1'b1;
        end
        ipSymbolValid = 1'b0;
        ipCfgWrite    = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
